// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU (magnitudes in, sign fix-up at the end).
// Optional: define DIV_EARLY_OUT_EN to skip CALC when divisor==0 or dividend<divisor.
module div_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            neg_q,
   input  logic            neg_r,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state;
   logic [XLEN-1:0] dq;    // dividend shifts out the top, quotient bits shift in the bottom
   logic [XLEN-1:0] dvs;
   logic [XLEN:0]   rem;   // top bit is always 0; the extra width keeps the trial subtract exact
   logic [CW-1:0]   cnt;
   logic            nq;
   logic            nr;

   logic [XLEN+1:0] sh;
   logic [XLEN+1:0] trial;
   logic            borrow;

   always_comb begin
      sh     = {rem, dq[XLEN-1]};
      trial  = sh - {2'b00, dvs};
      borrow = trial[XLEN+1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dq        <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         nq        <= 1'b0;
         nr        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     dq    <= dividend;
                     dvs   <= divisor;
                     // x/0 keeps the all-ones quotient regardless of operand signs
                     nq    <= neg_q && (divisor != '0);
                     nr    <= neg_r;
                     rem   <= '0;
                     cnt   <= CW'(XLEN - 1);
                     busy  <= 1'b1;
                     state <= CALC;
`ifdef DIV_EARLY_OUT_EN
                     if ((divisor == '0) || (dividend < divisor)) begin
                        dq    <= (divisor == '0) ? '1 : '0;
                        rem   <= {1'b0, dividend};
                        state <= FIX;
                     end
`endif
                  end
               end
               CALC: begin
                  dq  <= {dq[XLEN-2:0], ~borrow};
                  rem <= borrow ? sh[XLEN:0] : trial[XLEN:0];
                  if (cnt == '0) state <= FIX;
                  else           cnt   <= cnt - 1'b1;
               end
               FIX: begin
                  quotient  <= nq ? -dq : dq;
                  remainder <= nr ? -rem[XLEN-1:0] : rem[XLEN-1:0];
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
